// File: rtl/qdrc_cmd_sched.sv
// QDR command scheduler: queues user read/write bursts and issues them to the PHY in
// alternating read/write slots, then reassembles read returns into full bursts.
module qdrc_cmd_sched #(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 4,
    parameter int ADDR_WIDTH = 21,
    parameter int RD_LATENCY = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    phy_rdy,
    input  logic                    usr_wr_en,
    input  logic [ADDR_WIDTH-1:0]   usr_wr_addr,
    input  logic [4*DATA_WIDTH-1:0] usr_wr_data,
    input  logic [4*BW_WIDTH-1:0]   usr_wr_be,
    output logic                    usr_wr_rdy,
    input  logic                    usr_rd_en,
    input  logic [ADDR_WIDTH-1:0]   usr_rd_addr,
    output logic                    usr_rd_rdy,
    output logic [4*DATA_WIDTH-1:0] usr_rd_data,
    output logic                    usr_rd_dvld,
    output logic [ADDR_WIDTH-1:0]   phy_addr,
    output logic                    phy_wr_strb,
    output logic [2*DATA_WIDTH-1:0] phy_wr_data,
    output logic [2*BW_WIDTH-1:0]   phy_wr_ben,
    output logic                    phy_rd_strb,
    input  logic [2*DATA_WIDTH-1:0] phy_rd_data
);

    // state   | meaning
    // SLOT_RD | read slot: pop the read FIFO if it holds a request
    // SLOT_WR | write slot: pop the write FIFO if it holds a request
    typedef enum logic {SLOT_RD = 1'b0, SLOT_WR = 1'b1} slot_e;

    slot_e slot, slot_nxt;
    logic  rd_pop, wr_pop, rd_push, wr_push;

    logic [ADDR_WIDTH-1:0]   wr_addr_mem [4];
    logic [4*DATA_WIDTH-1:0] wr_data_mem [4];
    logic [4*BW_WIDTH-1:0]   wr_be_mem   [4];
    logic [ADDR_WIDTH-1:0]   rd_addr_mem [4];
    logic [1:0]              wr_wptr, wr_rptr, rd_wptr, rd_rptr;
    logic [2:0]              wr_cnt, rd_cnt;

    logic [2*DATA_WIDTH-1:0] wr_hi_data;
    logic [2*BW_WIDTH-1:0]   wr_hi_ben;
    logic [RD_LATENCY-1:0]   rd_tag;
    logic                    rd_hi_pend;
    logic [2*DATA_WIDTH-1:0] rd_lo;

    assign usr_wr_rdy = (wr_cnt != 3'd4);
    assign usr_rd_rdy = (rd_cnt != 3'd4);
    assign wr_push    = usr_wr_en && usr_wr_rdy;
    assign rd_push    = usr_rd_en && usr_rd_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) slot <= SLOT_RD;
        else       slot <= slot_nxt;
    end

    // Slot parks on SLOT_RD while the PHY is not ready.
    always_comb begin
        slot_nxt = SLOT_RD;
        rd_pop   = 1'b0;
        wr_pop   = 1'b0;
        case (slot)
            SLOT_RD: if (phy_rdy) begin
                slot_nxt = SLOT_WR;
                rd_pop   = (rd_cnt != 3'd0);
            end
            SLOT_WR: if (phy_rdy) begin
                slot_nxt = SLOT_RD;
                wr_pop   = (wr_cnt != 3'd0);
            end
            default: slot_nxt = SLOT_RD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_addr_mem[wr_wptr] <= usr_wr_addr;
            wr_data_mem[wr_wptr] <= usr_wr_data;
            wr_be_mem[wr_wptr]   <= usr_wr_be;
        end
        if (rd_push) rd_addr_mem[rd_wptr] <= usr_rd_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_wptr <= '0;
            wr_rptr <= '0;
            wr_cnt  <= '0;
            rd_wptr <= '0;
            rd_rptr <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_push) wr_wptr <= wr_wptr + 2'd1;
            if (wr_pop)  wr_rptr <= wr_rptr + 2'd1;
            if (rd_push) rd_wptr <= rd_wptr + 2'd1;
            if (rd_pop)  rd_rptr <= rd_rptr + 2'd1;
            case ({wr_push, wr_pop})
                2'b10:   wr_cnt <= wr_cnt + 3'd1;
                2'b01:   wr_cnt <= wr_cnt - 3'd1;
                default: wr_cnt <= wr_cnt;
            endcase
            case ({rd_push, rd_pop})
                2'b10:   rd_cnt <= rd_cnt + 3'd1;
                2'b01:   rd_cnt <= rd_cnt - 3'd1;
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    // Upper beat pair follows the strobe cycle regardless of phy_rdy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phy_addr    <= '0;
            phy_wr_strb <= 1'b0;
            phy_rd_strb <= 1'b0;
            phy_wr_data <= '0;
            phy_wr_ben  <= '0;
            wr_hi_data  <= '0;
            wr_hi_ben   <= '0;
        end else begin
            phy_rd_strb <= rd_pop;
            phy_wr_strb <= wr_pop;
            if (rd_pop)      phy_addr <= rd_addr_mem[rd_rptr];
            else if (wr_pop) phy_addr <= wr_addr_mem[wr_rptr];
            else             phy_addr <= '0;
            if (wr_pop) begin
                phy_wr_data <= wr_data_mem[wr_rptr][2*DATA_WIDTH-1:0];
                phy_wr_ben  <= wr_be_mem[wr_rptr][2*BW_WIDTH-1:0];
                wr_hi_data  <= wr_data_mem[wr_rptr][4*DATA_WIDTH-1:2*DATA_WIDTH];
                wr_hi_ben   <= wr_be_mem[wr_rptr][4*BW_WIDTH-1:2*BW_WIDTH];
            end else if (phy_wr_strb) begin
                phy_wr_data <= wr_hi_data;
                phy_wr_ben  <= wr_hi_ben;
            end else begin
                phy_wr_data <= '0;
                phy_wr_ben  <= '0;
            end
        end
    end

    // Tag bit k is set k+1 cycles after the strobe; the top bit marks the first beat pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_tag      <= '0;
            rd_hi_pend  <= 1'b0;
            rd_lo       <= '0;
            usr_rd_data <= '0;
            usr_rd_dvld <= 1'b0;
        end else begin
            rd_tag      <= {rd_tag[RD_LATENCY-2:0], phy_rd_strb};
            rd_hi_pend  <= rd_tag[RD_LATENCY-1];
            usr_rd_dvld <= rd_hi_pend;
            if (rd_tag[RD_LATENCY-1]) rd_lo <= phy_rd_data;
            if (rd_hi_pend) usr_rd_data <= {phy_rd_data, rd_lo};
        end
    end

endmodule

// File: tb/tb_qdrc_cmd_sched.sv
// Directed bench for qdrc_cmd_sched: a PHY model returns read data a fixed latency after
// each observed read strobe, and a monitor logs and checks every command cycle.
module tb_qdrc_cmd_sched;

    localparam int DW  = 36;
    localparam int BW  = 4;
    localparam int AW  = 21;
    localparam int RDL = 10;

    logic            clk;
    logic            reset;
    logic            phy_rdy;
    logic            usr_wr_en;
    logic [AW-1:0]   usr_wr_addr;
    logic [4*DW-1:0] usr_wr_data;
    logic [4*BW-1:0] usr_wr_be;
    logic            usr_wr_rdy;
    logic            usr_rd_en;
    logic [AW-1:0]   usr_rd_addr;
    logic            usr_rd_rdy;
    logic [4*DW-1:0] usr_rd_data;
    logic            usr_rd_dvld;
    logic [AW-1:0]   phy_addr;
    logic            phy_wr_strb;
    logic [2*DW-1:0] phy_wr_data;
    logic [2*BW-1:0] phy_wr_ben;
    logic            phy_rd_strb;
    logic [2*DW-1:0] phy_rd_data;

    qdrc_cmd_sched #(.DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .reset(reset), .phy_rdy(phy_rdy),
        .usr_wr_en(usr_wr_en), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data),
        .usr_wr_be(usr_wr_be), .usr_wr_rdy(usr_wr_rdy),
        .usr_rd_en(usr_rd_en), .usr_rd_addr(usr_rd_addr), .usr_rd_rdy(usr_rd_rdy),
        .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
        .phy_addr(phy_addr), .phy_wr_strb(phy_wr_strb), .phy_wr_data(phy_wr_data),
        .phy_wr_ben(phy_wr_ben), .phy_rd_strb(phy_rd_strb), .phy_rd_data(phy_rd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rbeat(input logic [AW-1:0] a, input int k);
        return {a, 15'(k + 1)};
    endfunction

    function automatic logic [4*DW-1:0] burst(input logic [AW-1:0] a);
        return {rbeat(a, 3), rbeat(a, 2), rbeat(a, 1), rbeat(a, 0)};
    endfunction

    function automatic logic [4*DW-1:0] wdat(input int i);
        return {DW'(i*16+3), DW'(i*16+2), DW'(i*16+1), DW'(i*16)};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // logs filled by the monitor
    int              cyc = 0;
    int              rd_cnt = 0;
    int              wr_cnt = 0;
    logic [AW-1:0]   wr_addr_q[$];
    logic [2*DW-1:0] wr_lo_q[$];
    logic [2*DW-1:0] wr_hi_q[$];
    logic [2*BW-1:0] wr_blo_q[$];
    logic [2*BW-1:0] wr_bhi_q[$];
    logic [AW-1:0]   rd_addr_q[$];
    logic [4*DW-1:0] ret_q[$];
    int              kind_q[$];
    int              scyc_q[$];
    logic [2*DW-1:0] sd[64];
    bit              sv[64];
    bit              prev_wr = 1'b0;

    always @(posedge clk) begin
        int idx;
        cyc = cyc + 1;
        #1;
        idx = cyc % 64;
        if (sv[idx]) begin
            phy_rd_data = sd[idx];
            sv[idx] = 1'b0;
        end else begin
            phy_rd_data = '0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_wr = 1'b0;
        end else begin
            if (phy_wr_strb || phy_rd_strb)
                check_val("strb_excl", 256'(phy_wr_strb & phy_rd_strb), 256'(0));
            else
                check_val("addr_idle", 256'(phy_addr), 256'(0));
            if (!phy_wr_strb && !prev_wr)
                check_val("wr_data_idle", 256'({phy_wr_data, phy_wr_ben}), 256'(0));
            if (prev_wr) begin
                wr_hi_q.push_back(phy_wr_data);
                wr_bhi_q.push_back(phy_wr_ben);
            end
            if (phy_wr_strb) begin
                wr_cnt++;
                wr_addr_q.push_back(phy_addr);
                wr_lo_q.push_back(phy_wr_data);
                wr_blo_q.push_back(phy_wr_ben);
                kind_q.push_back(1);
                scyc_q.push_back(cyc);
            end
            if (phy_rd_strb) begin
                rd_cnt++;
                rd_addr_q.push_back(phy_addr);
                kind_q.push_back(0);
                scyc_q.push_back(cyc);
                sd[(cyc + RDL) % 64]     = {rbeat(phy_addr, 1), rbeat(phy_addr, 0)};
                sv[(cyc + RDL) % 64]     = 1'b1;
                sd[(cyc + RDL + 1) % 64] = {rbeat(phy_addr, 3), rbeat(phy_addr, 2)};
                sv[(cyc + RDL + 1) % 64] = 1'b1;
            end
            if (usr_rd_dvld) ret_q.push_back(usr_rd_data);
            prev_wr = phy_wr_strb;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [4*DW-1:0] d, input logic [4*BW-1:0] be);
        usr_wr_en = 1'b1; usr_wr_addr = a; usr_wr_data = d; usr_wr_be = be;
        step(1);
        usr_wr_en = 1'b0;
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        usr_rd_en = 1'b1; usr_rd_addr = a;
        step(1);
        usr_rd_en = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_lo_q.delete(); wr_hi_q.delete();
        wr_blo_q.delete(); wr_bhi_q.delete(); rd_addr_q.delete();
        ret_q.delete(); kind_q.delete(); scyc_q.delete();
    endtask

    initial begin
        int rc, wc, target;
        logic [4*BW-1:0] be;
        reset = 1'b1; phy_rdy = 1'b0; phy_rd_data = '0;
        usr_wr_en = 1'b0; usr_wr_addr = '0; usr_wr_data = '0; usr_wr_be = '0;
        usr_rd_en = 1'b0; usr_rd_addr = '0;
        for (int i = 0; i < 64; i++) begin sv[i] = 1'b0; sd[i] = '0; end
        step(2);

        check_val("rst_wr_rdy",  256'(usr_wr_rdy),  256'(1));
        check_val("rst_rd_rdy",  256'(usr_rd_rdy),  256'(1));
        check_val("rst_phy_out", 256'({phy_addr, phy_wr_strb, phy_rd_strb, phy_wr_data, phy_wr_ben}), 256'(0));
        check_val("rst_rd_out",  256'({usr_rd_data, usr_rd_dvld}), 256'(0));
        reset = 1'b0;
        step(2);

        // fill write FIFO while PHY not ready; 5th push is dropped
        for (int i = 0; i < 4; i++) push_wr(AW'(32'h10 + i), wdat(i), 16'(16'h8421 + i));
        check_val("t1_wr_full", 256'(usr_wr_rdy), 256'(0));
        push_wr(21'h99, wdat(9), 16'hFFFF);
        step(5);
        check_val("t1_no_strb", 256'(wr_cnt + rd_cnt), 256'(0));
        phy_rdy = 1'b1;
        step(14);
        check_val("t1_wr_cnt", 256'(wr_cnt), 256'(4));
        check_val("t1_wr_rdy", 256'(usr_wr_rdy), 256'(1));
        for (int i = 0; i < 4; i++) begin
            be = 16'(16'h8421 + i);
            check_val("t1_addr", 256'(wr_addr_q[i]), 256'(32'h10 + i));
            check_val("t1_lo",   256'(wr_lo_q[i]),   256'({DW'(i*16+1), DW'(i*16)}));
            check_val("t1_hi",   256'(wr_hi_q[i]),   256'({DW'(i*16+3), DW'(i*16+2)}));
            check_val("t1_blo",  256'(wr_blo_q[i]),  256'(be[7:0]));
            check_val("t1_bhi",  256'(wr_bhi_q[i]),  256'(be[15:8]));
        end

        // single write
        clear_logs();
        push_wr(21'h1234, {36'd4, 36'd3, 36'd2, 36'd1}, 16'hFFFF);
        step(6);
        check_val("t2_cnt",  256'(wr_addr_q.size()), 256'(1));
        check_val("t2_addr", 256'(wr_addr_q[0]), 256'(21'h1234));
        check_val("t2_lo",   256'(wr_lo_q[0]),   256'({36'd2, 36'd1}));
        check_val("t2_hi",   256'(wr_hi_q[0]),   256'({36'd4, 36'd3}));
        check_val("t2_ben",  256'({wr_blo_q[0], wr_bhi_q[0]}), 256'(16'hFFFF));

        // single read, latency 10
        clear_logs();
        push_rd(21'h5);
        for (int k = 0; k < 40 && ret_q.size() < 1; k++) step(1);
        step(8);
        check_val("t3_ret_cnt", 256'(ret_q.size()), 256'(1));
        check_val("t3_ret", 256'(ret_q[0]),
                  256'({36'h000028004, 36'h000028003, 36'h000028002, 36'h000028001}));
        check_val("t3_rd_addr", 256'(rd_addr_q[0]), 256'(21'h5));

        // sustained mixed traffic
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            usr_rd_en = 1'b1; usr_rd_addr = AW'(32'h100 + i);
            push_wr(AW'(32'h200 + i), wdat(i + 4), 16'hFFFF);
        end
        usr_rd_en = 1'b0;
        step(30);
        check_val("t4_strb_cnt", 256'(kind_q.size()), 256'(8));
        for (int i = 1; i < 8; i++) begin
            check_val("t4_alt_kind", 256'(kind_q[i] != kind_q[i-1]), 256'(1));
            check_val("t4_alt_cyc",  256'(scyc_q[i] - scyc_q[i-1]), 256'(1));
        end
        check_val("t4_ret_cnt", 256'(ret_q.size()), 256'(4));
        for (int i = 0; i < 4; i++) begin
            check_val("t4_rd_addr", 256'(rd_addr_q[i]), 256'(32'h100 + i));
            check_val("t4_wr_addr", 256'(wr_addr_q[i]), 256'(32'h200 + i));
            check_val("t4_wr_hi",   256'(wr_hi_q[i]), 256'({DW'((i+4)*16+3), DW'((i+4)*16+2)}));
            check_val("t4_ret",     256'(ret_q[i]), 256'(burst(AW'(32'h100 + i))));
        end

        // phy_rdy drop one cycle after a write strobe, read in flight
        clear_logs();
        target = rd_cnt + 1;
        push_rd(21'h77);
        for (int k = 0; k < 10 && rd_cnt < target; k++) step(1);
        check_val("t5_rd_issue", 256'(rd_cnt >= target), 256'(1));
        target = wr_cnt + 1;
        push_wr(21'h88, wdat(5), 16'h5A3C);
        for (int k = 0; k < 10 && wr_cnt < target; k++) step(1);
        check_val("t5_wr_issue", 256'(wr_cnt >= target), 256'(1));
        phy_rdy = 1'b0;
        rc = rd_cnt; wc = wr_cnt;
        push_rd(21'h79);
        push_wr(21'h89, wdat(6), 16'hFFFF);
        step(25);
        check_val("t5_wr_hi",    256'(wr_hi_q[0]), 256'({DW'(5*16+3), DW'(5*16+2)}));
        check_val("t5_wr_bhi",   256'(wr_bhi_q[0]), 256'(8'h5A));
        check_val("t5_held_rd",  256'(rd_cnt), 256'(rc));
        check_val("t5_held_wr",  256'(wr_cnt), 256'(wc));
        check_val("t5_ret_cnt",  256'(ret_q.size()), 256'(1));
        check_val("t5_ret",      256'(ret_q[0]), 256'(burst(21'h77)));
        phy_rdy = 1'b1;
        step(25);
        check_val("t5_resume_rd", 256'(rd_cnt), 256'(rc + 1));
        check_val("t5_resume_wr", 256'(wr_cnt), 256'(wc + 1));
        check_val("t5_wr_addr2",  256'(wr_addr_q[1]), 256'(21'h89));
        check_val("t5_ret_cnt2",  256'(ret_q.size()), 256'(2));
        check_val("t5_ret2",      256'(ret_q[1]), 256'(burst(21'h79)));

        // reset with two reads in flight
        clear_logs();
        target = rd_cnt + 2;
        push_rd(21'h31);
        push_rd(21'h32);
        for (int k = 0; k < 10 && rd_cnt < target; k++) step(1);
        check_val("t6_rd_issue", 256'(rd_cnt >= target), 256'(1));
        step(1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_phy_out", 256'({phy_addr, phy_wr_strb, phy_rd_strb, phy_wr_data, phy_wr_ben}), 256'(0));
        check_val("t6_rd_data", 256'(usr_rd_data), 256'(0));
        check_val("t6_rd_dvld", 256'(usr_rd_dvld), 256'(0));
        check_val("t6_rdy",     256'({usr_wr_rdy, usr_rd_rdy}), 256'(2'b11));
        step(1);
        reset = 1'b0;
        step(30);
        check_val("t6_no_ret", 256'(ret_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
